row_result_collector: RTL and testbench

//  - Downstream of the row-by-vector stage: captures each 32-bit row dot-product on decoder_read_now pulse.
//  - Packs NI consecutive row results into one NI*element_width word, buffers words in a small FIFO.
//  - Streams words out with a valid/ready handshake and word address, giving the next vector/memory stage A*p in NI-wide chunks.

---
 rtl/row_result_collector.sv | 178 +++++++++++++++++
 tb/tb_row_result_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/row_result_collector.sv
// row_result_collector
//   Captures row dot-products strobed by decoder_read_now and packs NI of
//   them into one word. Packed words go into a small FIFO and stream out over
//   a valid/ready handshake, each tagged with its word address.
//   Optional feature macro: ROW_COLLECTOR_STATUS_EN adds the overflow and
//   rows_captured status outputs.
module row_result_collector #(
   parameter int NI            = 8,
   parameter int element_width = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_WIDTH    = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_collect,
   input  logic [31:0]                   no_of_rows,
   input  logic [element_width-1:0]      result,
   input  logic                          decoder_read_now,
   output logic [NI*element_width-1:0]   out_word,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ADDR_WIDTH-1:0]         out_addr,
   output logic                          collect_done
`ifdef ROW_COLLECTOR_STATUS_EN
   ,
   output logic                          overflow,
   output logic [31:0]                   rows_captured
`endif
);

   localparam int WORD_W = NI * element_width;
   localparam int LANE_W = (NI > 1) ? $clog2(NI) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [31:0]         rows_target_q, rows_target_d;
   logic [31:0]         rows_seen_q, rows_seen_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [WORD_W-1:0]   pack_q, pack_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef ROW_COLLECTOR_STATUS_EN
   logic                ovf_q, ovf_d;
`endif

   logic [WORD_W-1:0]   mem [FIFO_DEPTH];
   logic [WORD_W-1:0]   push_word;
   logic                strobe_ok, last_row, push, push_ok, pop, fifo_full;

   // Word to push: pack register with the current result merged into its lane,
   // so the final row of a word goes out on the same edge it arrives.
   always_comb begin
      push_word = pack_q;
      for (int j = 0; j < NI; j++) begin
         if (lane_q == LANE_W'(j)) begin
            push_word[j*element_width +: element_width] = result;
         end
      end
   end

   // Handshake and FIFO status decode; start_collect masks a same-cycle strobe.
   always_comb begin
      strobe_ok = (state_q == S_COLLECT) && decoder_read_now && !start_collect;
      last_row  = ((rows_seen_q + 32'd1) == rows_target_q);
      push      = strobe_ok && ((lane_q == LANE_W'(NI - 1)) || last_row);
      fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
      out_valid = (count_q != '0);
      pop       = out_valid && out_ready;
      // A full FIFO still takes a word when the head leaves in the same cycle.
      push_ok   = push && (!fifo_full || pop);
   end

   assign out_word     = out_valid ? mem[rd_ptr_q] : '0;
   assign out_addr     = addr_q;
   assign collect_done = (state_q == S_DONE);
`ifdef ROW_COLLECTOR_STATUS_EN
   assign overflow      = ovf_q;
   assign rows_captured = rows_seen_q;
`endif

   // Next-state logic for the FSM, row counters, pack register and FIFO pointers.
   always_comb begin
      state_d       = state_q;
      rows_target_d = rows_target_q;
      rows_seen_d   = rows_seen_q;
      lane_d        = lane_q;
      pack_d        = pack_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      addr_d        = addr_q;
`ifdef ROW_COLLECTOR_STATUS_EN
      ovf_d         = ovf_q;
`endif
      if (start_collect) begin
         rows_target_d = no_of_rows;
         rows_seen_d   = '0;
         lane_d        = '0;
         pack_d        = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         addr_d        = '0;
`ifdef ROW_COLLECTOR_STATUS_EN
         ovf_d         = 1'b0;
`endif
         state_d       = (no_of_rows == 32'd0) ? S_DONE : S_COLLECT;
      end else begin
         if (strobe_ok) begin
            rows_seen_d = rows_seen_q + 32'd1;
            if (push) begin
               lane_d = '0;
               pack_d = '0;
               if (last_row) state_d = S_DRAIN;
            end else begin
               lane_d = lane_q + LANE_W'(1);
               pack_d = push_word;
            end
         end
`ifdef ROW_COLLECTOR_STATUS_EN
         if (push && !push_ok) ovf_d = 1'b1;
`endif
         if (state_q == S_DRAIN && count_q == '0) state_d = S_DONE;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_WIDTH'(1);
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Counters, pack register, FIFO pointers and output address.
   always_ff @(posedge clk) begin
      if (reset) begin
         rows_target_q <= '0;
         rows_seen_q   <= '0;
         lane_q        <= '0;
         pack_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         addr_q        <= '0;
`ifdef ROW_COLLECTOR_STATUS_EN
         ovf_q         <= 1'b0;
`endif
      end else begin
         rows_target_q <= rows_target_d;
         rows_seen_q   <= rows_seen_d;
         lane_q        <= lane_d;
         pack_q        <= pack_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         addr_q        <= addr_d;
`ifdef ROW_COLLECTOR_STATUS_EN
         ovf_q         <= ovf_d;
`endif
      end
   end

   // FIFO storage; contents are only visible through out_word while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= push_word;
   end

endmodule

// File: tb/tb_row_result_collector.sv
// Bench for row_result_collector: randomized rows, scoreboard of packed words.
module tb_row_result_collector;
   localparam int NI = 8, EW = 32, DEPTH = 4, AW = 16, WW = NI * EW;

   logic          clk = 1'b0;
   logic          reset, start_collect, decoder_read_now, out_ready;
   logic [31:0]   no_of_rows;
   logic [EW-1:0] result;
   logic [WW-1:0] out_word;
   logic          out_valid, collect_done;
   logic [AW-1:0] out_addr;
`ifdef ROW_COLLECTOR_STATUS_EN
   logic          overflow;
   logic [31:0]   rows_captured;
`endif

   always #5 clk = ~clk;

   row_result_collector #(.NI(NI), .element_width(EW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start_collect(start_collect), .no_of_rows(no_of_rows),
      .result(result), .decoder_read_now(decoder_read_now), .out_word(out_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .collect_done(collect_done)
`ifdef ROW_COLLECTOR_STATUS_EN
      , .overflow(overflow), .rows_captured(rows_captured)
`endif
   );

   typedef struct { logic [WW-1:0] w; logic [AW-1:0] a; } exp_t;
   exp_t exp_q[$];
   int   errors = 0, checks = 0;
   int   rdy_mode = 0;   // 0 hold, 1 toggle each cycle, 2 random
   bit   mon_en = 1'b1;

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: compares the FIFO head against the scoreboard, pops on handshake.
   always @(negedge clk) begin
      if (mon_en && !reset && !start_collect && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: actual addr=%0d word=%0h required=no output", out_addr, out_word);
         end else begin
            chk("out_word", out_word, exp_q[0].w);
            chk("out_addr", WW'(out_addr), WW'(exp_q[0].a));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         1: out_ready = ~out_ready;
         2: out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic do_start(input int n);
      start_collect = 1'b1;
      no_of_rows    = n;
      exp_q.delete();
      tick();
      start_collect = 1'b0;
   endtask

   task automatic strobe(input logic [EW-1:0] v);
      decoder_read_now = 1'b1;
      result           = v;
      tick();
      decoder_read_now = 1'b0;
   endtask

   // Reference: row i lands in word i/NI, lane i%NI; missing lanes are zero.
   // Only the first 'keep' words are expected (keep<0: all of them).
   task automatic run_rows(input int n, input int keep, input int gap_max, input bit seq);
      logic [EW-1:0] res[$];
      int nw;
      for (int i = 0; i < n; i++) res.push_back(seq ? EW'(i + 1) : EW'($urandom));
      nw = (n + NI - 1) / NI;
      for (int w = 0; w < nw; w++) begin
         exp_t e;
         e.w = '0;
         for (int l = 0; l < NI; l++)
            if (w * NI + l < n) e.w[l*EW +: EW] = res[w*NI + l];
         e.a = AW'(w);
         if (keep < 0 || w < keep) exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         strobe(res[i]);
         if (i < n - 1) repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (collect_done !== 1'b1 && c < budget) begin
         tick();
         c++;
      end
      chk("collect_done", WW'(collect_done), WW'(1'b1));
      chk("sb_empty", WW'(exp_q.size()), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start_collect = 1'b0; decoder_read_now = 1'b0;
      out_ready = 1'b1; no_of_rows = '0; result = '0;
      tick(); tick();
      chk("rst_out_valid", WW'(out_valid), '0);
      chk("rst_out_word", out_word, '0);
      chk("rst_out_addr", WW'(out_addr), '0);
      chk("rst_collect_done", WW'(collect_done), '0);
      reset = 1'b0;
      tick();

      // 16 rows of 1..16, always ready
      do_start(16);
      run_rows(16, -1, 0, 1'b1);
      wait_done(30);

      // 3 rows: one partial word, valid right after the last strobe
      do_start(3);
      run_rows(3, -1, 0, 1'b0);
      chk("partial_valid_latency", WW'(out_valid), WW'(1'b1));
      wait_done(30);

      // 40 rows with consumer stalled: 4 words kept, 5th dropped
      out_ready = 1'b0;
      do_start(40);
      run_rows(40, DEPTH, 0, 1'b0);
      repeat (3) tick();
      chk("ovf_out_valid", WW'(out_valid), WW'(1'b1));
      chk("ovf_collect_done", WW'(collect_done), '0);
      chk("ovf_out_addr", WW'(out_addr), '0);
`ifdef ROW_COLLECTOR_STATUS_EN
      chk("ovf_flag", WW'(overflow), WW'(1'b1));
      chk("rows_captured", WW'(rows_captured), WW'(40));
`endif
      out_ready = 1'b1;
      wait_done(30);

      // 64 back-to-back rows, ready toggling every cycle
      rdy_mode = 1;
      do_start(64);
      run_rows(64, -1, 0, 1'b0);
      wait_done(100);
      rdy_mode = 0;
      out_ready = 1'b1;

      // restart after 5 of 16 rows; restart beats a same-cycle strobe
      do_start(16);
      for (int i = 0; i < 5; i++) strobe(EW'($urandom));
      start_collect = 1'b1; no_of_rows = 8; decoder_read_now = 1'b1; result = 32'hDEAD_BEEF;
      exp_q.delete();
      tick();
      start_collect = 1'b0; decoder_read_now = 1'b0;
      run_rows(8, -1, 1, 1'b0);
      wait_done(30);

      // zero rows completes immediately
      do_start(0);
      chk("zero_rows_done", WW'(collect_done), WW'(1'b1));
      chk("zero_rows_valid", WW'(out_valid), '0);

      // reset mid-collect with a word held in the FIFO
      out_ready = 1'b0;
      do_start(16);
      mon_en = 1'b0;
      for (int i = 0; i < 11; i++) strobe(EW'($urandom));
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      mon_en = 1'b1;
      chk("rstmid_out_valid", WW'(out_valid), '0);
      chk("rstmid_collect_done", WW'(collect_done), '0);
      chk("rstmid_out_addr", WW'(out_addr), '0);
      for (int i = 0; i < 10; i++) strobe(EW'($urandom));
      tick();
      chk("rstmid_ignored_valid", WW'(out_valid), '0);
      chk("rstmid_ignored_done", WW'(collect_done), '0);
      out_ready = 1'b1;

      // randomized runs with random gaps and random consumer stalls
      rdy_mode = 2;
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 30);
         do_start(n);
         run_rows(n, -1, 2, 1'b0);
         wait_done(200);
      end
      rdy_mode = 0;
      out_ready = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
